// File: rtl/uio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// uio_bus_arbiter
//
// Shares the eight bidirectional uio pins between two on-chip requesters:
//   requester 0 - edge-counter register port
//   requester 1 - debug/test port
// Round-robin arbitration with a bus-float turnaround gap before every grant
// and an optional forced release so a waiting requester is never starved.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   ena      block enable; 0 releases the owner and blocks new grants
//   req      per-requester level request
//   out0/oe0 requester 0 drive data / per-pin output enable
//   out1/oe1 requester 1 drive data / per-pin output enable
//   uio_in   pad input data
//   uio_out  pad drive data (muxed from the registered grant)
//   uio_oe   pad output enables, 1 = drive (muxed from the registered grant)
//   grant    registered one-hot grant, 00 = none
//   rd_data  uio_in registered one cycle, seen by both requesters
//   busy     1 while in TURN or OWN
// -----------------------------------------------------------------------------
module uio_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,   // 0..15, 0 = no float gap
    parameter int unsigned MAX_HOLD    = 16   // 0..255, 0 = no preemption
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    input  logic [7:0] out0,
    input  logic [7:0] oe0,
    input  logic [7:0] out1,
    input  logic [7:0] oe1,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [1:0] grant,
    output logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    localparam logic       HAS_TURN    = (TURN_CYCLES != 0);
    localparam logic       HAS_PREEMPT = (MAX_HOLD != 0);
    localparam logic [3:0] TURN_LAST   = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);
    localparam logic [7:0] HOLD_MAX    = 8'(MAX_HOLD);

    state_t     state_r, state_s;
    logic       win_r, win_s;      // requester index being turned to / owning
    logic       last_r, last_s;    // index of the most recent owner
    logic [7:0] hold_r, hold_s;    // completed OWN cycles of the current owner
    logic [3:0] turn_r, turn_s;    // completed TURN cycles
    logic [1:0] grant_r, grant_s;
    logic [7:0] rd_data_r;

    logic       other_s;
    logic [7:0] hold_cur_s;        // OWN cycle count including the current cycle
    logic       release_s;

    // One-hot grant encoding of a requester index.
    function automatic logic [1:0] onehot(input logic idx);
        if (idx) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    // Winner selection: lone requester wins, a tie goes to the one that
    // did not own the bus last.
    function automatic logic pick_winner(input logic [1:0] r, input logic last);
        if (r == 2'b11) begin
            return ~last;
        end else begin
            return r[1];
        end
    endfunction

    // Next-state, counter and grant decode.
    always_comb begin
        state_s    = state_r;
        win_s      = win_r;
        last_s     = last_r;
        hold_s     = hold_r;
        turn_s     = turn_r;
        grant_s    = 2'b00;
        other_s    = ~win_r;
        hold_cur_s = (hold_r == 8'hFF) ? 8'hFF : (hold_r + 8'd1);
        release_s  = ~req[win_r] | ~ena |
                     (HAS_PREEMPT & req[other_s] & (hold_cur_s == HOLD_MAX));

        case (state_r)
            ST_IDLE: begin
                if (ena && (req != 2'b00)) begin
                    win_s = pick_winner(req, last_r);
                    if (HAS_TURN) begin
                        state_s = ST_TURN;
                        turn_s  = 4'd0;
                    end else begin
                        state_s = ST_OWN;
                        last_s  = win_s;
                        hold_s  = 8'd0;
                        grant_s = onehot(win_s);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_TURN: begin
                if (!ena || !req[win_r]) begin
                    // winner vanished during the gap: abandon without granting
                    state_s = ST_IDLE;
                    turn_s  = 4'd0;
                end else if (turn_r == TURN_LAST) begin
                    state_s = ST_OWN;
                    last_s  = win_r;
                    hold_s  = 8'd0;
                    grant_s = onehot(win_r);
                end else begin
                    turn_s = turn_r + 4'd1;
                end
            end

            ST_OWN: begin
                if (release_s) begin
                    if (ena && req[other_s]) begin
                        win_s = other_s;
                        if (HAS_TURN) begin
                            state_s = ST_TURN;
                            turn_s  = 4'd0;
                        end else begin
                            // no gap configured: hand over directly
                            state_s = ST_OWN;
                            last_s  = other_s;
                            hold_s  = 8'd0;
                            grant_s = onehot(other_s);
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    hold_s  = hold_cur_s;
                    grant_s = onehot(win_r);
                end
            end

            default: begin
                state_s = ST_IDLE;
                turn_s  = 4'd0;
                hold_s  = 8'd0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            win_r   <= 1'b0;
            last_r  <= 1'b1;
            hold_r  <= 8'd0;
            turn_r  <= 4'd0;
            grant_r <= 2'b00;
        end else begin
            state_r <= state_s;
            win_r   <= win_s;
            last_r  <= last_s;
            hold_r  <= hold_s;
            turn_r  <= turn_s;
            grant_r <= grant_s;
        end
    end

    // Pad input capture, independent of arbitration state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= 8'd0;
        end else begin
            rd_data_r <= uio_in;
        end
    end

    // Pad drive mux: pins float unless a grant is registered.
    always_comb begin
        uio_out = 8'd0;
        uio_oe  = 8'd0;
        case (grant_r)
            2'b01: begin
                uio_out = out0;
                uio_oe  = oe0;
            end
            2'b10: begin
                uio_out = out1;
                uio_oe  = oe1;
            end
            default: begin
                uio_out = 8'd0;
                uio_oe  = 8'd0;
            end
        endcase
    end

    assign grant   = grant_r;
    assign rd_data = rd_data_r;
    assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for uio_bus_arbiter. Three instances share stimulus:
//   a: TURN_CYCLES=1, MAX_HOLD=16
//   b: TURN_CYCLES=1, MAX_HOLD=4
//   c: TURN_CYCLES=0, MAX_HOLD=16
// A behavioural model (owner / pending winner / gap countdown) tracks all three.
// -----------------------------------------------------------------------------
module tb_uio_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] req;
    logic [7:0] out0, oe0, out1, oe1, uio_in;

    logic [7:0] uio_out_a, uio_oe_a, rd_data_a;
    logic [1:0] grant_a;
    logic       busy_a;
    logic [7:0] uio_out_b, uio_oe_b, rd_data_b;
    logic [1:0] grant_b;
    logic       busy_b;
    logic [7:0] uio_out_c, uio_oe_c, rd_data_c;
    logic [1:0] grant_c;
    logic       busy_c;

    int n_tests = 0;
    int n_fail  = 0;

    // model state per instance
    int         m_tc[3];
    int         m_mh[3];
    int         m_owner[3];   // -1 none, else requester index holding grant
    int         m_pend[3];    // -1 none, else winner waiting out the gap
    int         m_gap[3];     // float cycles still to elapse
    int         m_held[3];    // cycles the current owner has been granted
    int         m_last[3];
    logic [7:0] m_rd[3];

    always #5 clk = ~clk;

    uio_bus_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(16)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
        .out0(out0), .oe0(oe0), .out1(out1), .oe1(oe1), .uio_in(uio_in),
        .uio_out(uio_out_a), .uio_oe(uio_oe_a), .grant(grant_a),
        .rd_data(rd_data_a), .busy(busy_a));

    uio_bus_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
        .out0(out0), .oe0(oe0), .out1(out1), .oe1(oe1), .uio_in(uio_in),
        .uio_out(uio_out_b), .uio_oe(uio_oe_b), .grant(grant_b),
        .rd_data(rd_data_b), .busy(busy_b));

    uio_bus_arbiter #(.TURN_CYCLES(0), .MAX_HOLD(16)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
        .out0(out0), .oe0(oe0), .out1(out1), .oe1(oe1), .uio_in(uio_in),
        .uio_out(uio_out_c), .uio_oe(uio_oe_c), .grant(grant_c),
        .rd_data(rd_data_c), .busy(busy_c));

    // Model: start a grant toward requester w.
    task automatic model_give(input int i, input int w);
        if (m_tc[i] > 0) begin
            m_pend[i] = w;
            m_gap[i]  = m_tc[i];
        end else begin
            m_owner[i] = w;
            m_last[i]  = w;
            m_held[i]  = 0;
        end
    endtask

    // Model: one clock edge for every instance, using the sampled inputs.
    task automatic model_edge();
        int o;
        int oth;
        bit rel;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_owner[i] = -1;
                m_pend[i]  = -1;
                m_gap[i]   = 0;
                m_held[i]  = 0;
                m_last[i]  = 1;
                m_rd[i]    = 8'd0;
            end else begin
                m_rd[i] = uio_in;
                if (m_owner[i] >= 0) begin
                    o   = m_owner[i];
                    oth = 1 - o;
                    if (m_held[i] < 255) m_held[i]++;
                    rel = !req[o] || !ena ||
                          (m_mh[i] > 0 && req[oth] && m_held[i] == m_mh[i]);
                    if (rel) begin
                        m_owner[i] = -1;
                        if (ena && req[oth]) model_give(i, oth);
                    end
                end else if (m_pend[i] >= 0) begin
                    if (!ena || !req[m_pend[i]]) begin
                        m_pend[i] = -1;
                    end else begin
                        m_gap[i]--;
                        if (m_gap[i] == 0) begin
                            m_owner[i] = m_pend[i];
                            m_last[i]  = m_pend[i];
                            m_held[i]  = 0;
                            m_pend[i]  = -1;
                        end
                    end
                end else if (ena && req != 2'b00) begin
                    if (req == 2'b11) model_give(i, 1 - m_last[i]);
                    else              model_give(i, req[1] ? 1 : 0);
                end
            end
        end
    endtask

    // {grant, busy, uio_oe, uio_out, rd_data} predicted by the model
    function automatic logic [26:0] exp_vec(input int i);
        logic [1:0] g;
        logic [7:0] o;
        logic [7:0] e;
        g = (m_owner[i] < 0) ? 2'b00 : ((m_owner[i] == 1) ? 2'b10 : 2'b01);
        o = 8'd0;
        e = 8'd0;
        if (g == 2'b01) begin o = out0; e = oe0; end
        if (g == 2'b10) begin o = out1; e = oe1; end
        return {g, (m_owner[i] >= 0 || m_pend[i] >= 0), e, o, m_rd[i]};
    endfunction

    function automatic logic [26:0] act_vec(input int i);
        case (i)
            0:       return {grant_a, busy_a, uio_oe_a, uio_out_a, rd_data_a};
            1:       return {grant_b, busy_b, uio_oe_b, uio_out_b, rd_data_b};
            default: return {grant_c, busy_c, uio_oe_c, uio_out_c, rd_data_c};
        endcase
    endfunction

    // Advance one clock; outputs are stable at the following negedge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        ena   = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b11;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (act_vec(i) !== 27'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, act_vec(i), 27'd0);
            end
        end
        rst_n = 1'b1;
        req   = 2'b00;
    endtask

    task automatic test_single_req();
        do_reset();
        out0 = 8'hA5;
        oe0  = 8'hFF;
        req  = 2'b01;
        tick();
        n_tests++;
        if (grant_a !== 2'b00 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_turn: got grant=%b busy=%b expected grant=00 busy=1", grant_a, busy_a);
        end
        tick();
        n_tests++;
        if ({grant_a, uio_oe_a, uio_out_a} !== {2'b01, 8'hFF, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_grant: got %b/%h/%h expected 01/ff/a5", grant_a, uio_oe_a, uio_out_a);
        end
        req = 2'b00;
        tick();
        n_tests++;
        if (grant_a !== 2'b00 || uio_oe_a !== 8'h00) begin
            n_fail++;
            $display("FAIL single_release: got %b/%h expected 00/00", grant_a, uio_oe_a);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        int         changes;
        do_reset();
        req = 2'b11;
        tick();
        tick();
        n_tests++;
        if (grant_a !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_first: got %b expected 01", grant_a);
        end
        tick(); tick(); tick();
        req = 2'b10;
        tick();
        n_tests++;
        if (grant_a !== 2'b00 || uio_oe_a !== 8'h00) begin
            n_fail++;
            $display("FAIL rr_gap: got %b/%h expected 00/00", grant_a, uio_oe_a);
        end
        tick();
        n_tests++;
        if (grant_a !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_second: got %b expected 10", grant_a);
        end
        req     = 2'b11;
        prev    = 2'b10;
        changes = 0;
        for (int k = 0; k < 60 && changes < 2; k++) begin
            tick();
            if (grant_a !== 2'b00 && grant_a !== prev) begin
                n_tests++;
                if (grant_a !== ~prev) begin
                    n_fail++;
                    $display("FAIL rr_alternate: got %b expected %b", grant_a, ~prev);
                end
                prev = grant_a;
                changes++;
            end
        end
        n_tests++;
        if (changes < 2) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d owner changes expected 2", changes);
        end
    endtask

    task automatic test_preempt();
        int n01;
        do_reset();
        req = 2'b01;
        tick();
        tick();
        n01 = (grant_b === 2'b01) ? 1 : 0;
        req = 2'b11;
        for (int k = 0; k < 20 && grant_b === 2'b01; k++) begin
            tick();
            if (grant_b === 2'b01) n01++;
        end
        n_tests++;
        if (n01 != 4 || grant_b !== 2'b00) begin
            n_fail++;
            $display("FAIL preempt_hold: got %0d cycles then %b expected 4 cycles then 00", n01, grant_b);
        end
        tick();
        n_tests++;
        if (grant_b !== 2'b10) begin
            n_fail++;
            $display("FAIL preempt_switch: got %b expected 10", grant_b);
        end
        req = 2'b01;
        tick();
        tick();
        n_tests++;
        if (grant_b !== 2'b01) begin
            n_fail++;
            $display("FAIL preempt_regrant: got %b expected 01", grant_b);
        end
    endtask

    task automatic test_turn0();
        do_reset();
        oe0 = 8'h0F;
        req = 2'b10;
        tick();
        n_tests++;
        if (grant_c !== 2'b10) begin
            n_fail++;
            $display("FAIL turn0_latency: got %b expected 10", grant_c);
        end
        req = 2'b11;
        tick();
        tick();
        req = 2'b01;
        tick();
        n_tests++;
        if (grant_c !== 2'b01 || uio_oe_c !== 8'h0F) begin
            n_fail++;
            $display("FAIL turn0_nogap: got %b/%h expected 01/0f", grant_c, uio_oe_c);
        end
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        oe1 = 8'hFF;
        req = 2'b10;
        tick();
        tick();
        n_tests++;
        if (grant_a !== 2'b10 || uio_oe_a !== 8'hFF) begin
            n_fail++;
            $display("FAIL midrst_own: got %b/%h expected 10/ff", grant_a, uio_oe_a);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (grant_a !== 2'b00 || uio_oe_a !== 8'h00 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b/%h/%b expected 00/00/0", grant_a, uio_oe_a, busy_a);
        end
        req = 2'b00;
        tick();
        req = 2'b11;
        tick();
        tick();
        n_tests++;
        if (grant_a !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_tie: got %b expected 01", grant_a);
        end
    endtask

    task automatic test_ena_rd();
        do_reset();
        req = 2'b01;
        tick();
        tick();
        ena = 1'b0;
        tick();
        n_tests++;
        if (grant_a !== 2'b00) begin
            n_fail++;
            $display("FAIL ena_release: got %b expected 00", grant_a);
        end
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if ({grant_a, busy_a, grant_c, busy_c} !== 6'b000000) begin
                n_fail++;
                $display("FAIL ena_hold: got %b%b %b%b expected 000 000", grant_a, busy_a, grant_c, busy_c);
            end
        end
        uio_in = 8'h3C;
        tick();
        n_tests++;
        if ({rd_data_a, rd_data_b, rd_data_c} !== {3{8'h3C}}) begin
            n_fail++;
            $display("FAIL rd_idle: got %h %h %h expected 3c", rd_data_a, rd_data_b, rd_data_c);
        end
        ena    = 1'b1;
        uio_in = 8'h5A;
        tick();
        n_tests++;
        if ({rd_data_a, rd_data_c} !== {8'h5A, 8'h5A} || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_busy: got %h %h busy=%b expected 5a 5a busy=1", rd_data_a, rd_data_c, busy_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 11) == 0) req[1] = ~req[1];
            ena    = ($urandom_range(0, 39) != 0);
            rst_n  = ($urandom_range(0, 599) != 0);
            out0   = 8'($urandom);
            oe0    = 8'($urandom);
            out1   = 8'($urandom);
            oe1    = 8'($urandom);
            uio_in = 8'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random[%0d] cycle %0d: got %h expected %h", i, c, act_vec(i), exp_vec(i));
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        m_tc[0] = 1; m_mh[0] = 16;
        m_tc[1] = 1; m_mh[1] = 4;
        m_tc[2] = 0; m_mh[2] = 16;
        for (int i = 0; i < 3; i++) begin
            m_owner[i] = -1;
            m_pend[i]  = -1;
            m_gap[i]   = 0;
            m_held[i]  = 0;
            m_last[i]  = 1;
            m_rd[i]    = 8'd0;
        end
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = 2'b00;
        out0   = 8'd0;
        oe0    = 8'd0;
        out1   = 8'd0;
        oe1    = 8'd0;
        uio_in = 8'h77;

        test_reset();
        test_single_req();
        test_round_robin();
        test_preempt();
        test_turn0();
        test_reset_mid_own();
        test_ena_rd();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
